// File: rtl/alu_sequencer.sv
// Issue-side controller for the small ALU: owns a 4x4 register file, issues
// one instruction at a time, waits out the ALU latency and writes the result back.
module alu_sequencer #(
    parameter int DATA_W      = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_instr,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [1:0]        load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] alu_rs,
    output logic [DATA_W-1:0] alu_rt,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              result_valid,
    output logic [1:0]        result_rd,
    output logic [DATA_W-1:0] result_data,
    output logic              busy,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 4;
    localparam int CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   alu_rs_q, alu_rs_d;
    logic [DATA_W-1:0]   alu_rt_q, alu_rt_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic [1:0]          result_rd_q, result_rd_d;
    logic [DATA_W-1:0]   result_data_q, result_data_d;
    logic [DATA_W-1:0]   regfile_q [NREGS];
    logic [DATA_W-1:0]   regfile_d [NREGS];

    logic [1:0] instr_op, instr_rd, instr_rs, instr_rt;
    logic       load_take;
    logic       accept;
    logic       writeback;

    assign {instr_op, instr_rd, instr_rs, instr_rt} = in_instr;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        alu_rs_d      = alu_rs_q;
        alu_rt_d      = alu_rt_q;
        alu_op_d      = alu_op_q;
        result_rd_d   = result_rd_q;
        result_data_d = result_data_q;
        in_ready      = 1'b0;
        load_ready    = 1'b0;
        load_take     = 1'b0;
        accept        = 1'b0;
        writeback     = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending load wins the cycle; the instruction waits one cycle.
                load_ready = 1'b1;
                in_ready   = ~load_valid;
                load_take  = load_valid;
                accept     = in_valid & ~load_valid;
                if (accept) begin
                    alu_rs_d = regfile_q[instr_rs];
                    alu_rt_d = regfile_q[instr_rt];
                    alu_op_d = instr_op;
                    rd_d     = instr_rd;
                    cnt_d    = CNT_W'(ALU_LATENCY);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    writeback     = 1'b1;
                    result_rd_d   = rd_q;
                    result_data_d = alu_result;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_q          <= '0;
            alu_rs_q      <= '0;
            alu_rt_q      <= '0;
            alu_op_q      <= '0;
            result_rd_q   <= '0;
            result_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            alu_rs_q      <= alu_rs_d;
            alu_rt_q      <= alu_rt_d;
            alu_op_q      <= alu_op_d;
            result_rd_q   <= result_rd_d;
            result_data_q <= result_data_d;
        end
    end

    // Loads and writebacks never coincide: loads only happen in IDLE, writebacks in EXEC.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            always_comb begin
                regfile_d[gi] = regfile_q[gi];
                if (load_take && (load_addr == 2'(gi))) begin
                    regfile_d[gi] = load_data;
                end else if (writeback && (rd_q == 2'(gi))) begin
                    regfile_d[gi] = alu_result;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regfile_q[gi] <= '0;
                end else begin
                    regfile_q[gi] <= regfile_d[gi];
                end
            end
        end
    endgenerate

    assign alu_rs       = alu_rs_q;
    assign alu_rt       = alu_rt_q;
    assign alu_op       = alu_op_q;
    assign result_valid = (state_q == DONE);
    assign result_rd    = result_rd_q;
    assign result_data  = result_data_q;
    assign busy         = (state_q != IDLE);
    assign dbg_data     = regfile_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a registered-ALU instance (latency 1) driven from a
// vector table with a writeback scoreboard, plus a combinational-ALU instance (latency 0).
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Latency-1 instance signals
    logic       in_valid, in_ready, load_valid, load_ready;
    logic [7:0] in_instr;
    logic [1:0] load_addr, alu_op, result_rd, dbg_addr;
    logic [3:0] load_data, alu_rs, alu_rt, alu_result, result_data, dbg_data;
    logic       result_valid, busy;

    // Latency-0 instance signals
    logic       z_in_valid, z_in_ready, z_load_valid, z_load_ready;
    logic [7:0] z_in_instr;
    logic [1:0] z_load_addr, z_alu_op, z_result_rd, z_dbg_addr;
    logic [3:0] z_load_data, z_alu_rs, z_alu_rt, z_alu_result, z_result_data, z_dbg_data;
    logic       z_result_valid, z_busy;

    // ALU model: 00 add, 01 sub, 10 mul, 11 xor; results truncated to 4 bits
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        logic [7:0] p;
        p = 8'(a) * 8'(b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return p[3:0];
            default: return a ^ b;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_f(alu_rs, alu_rt, alu_op);
    assign z_alu_result = alu_f(z_alu_rs, z_alu_rt, z_alu_op);

    alu_sequencer #(.DATA_W(4), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op), .alu_result(alu_result),
        .result_valid(result_valid), .result_rd(result_rd), .result_data(result_data),
        .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    alu_sequencer #(.DATA_W(4), .ALU_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_instr(z_in_instr),
        .load_valid(z_load_valid), .load_ready(z_load_ready),
        .load_addr(z_load_addr), .load_data(z_load_data),
        .alu_rs(z_alu_rs), .alu_rt(z_alu_rt), .alu_op(z_alu_op), .alu_result(z_alu_result),
        .result_valid(z_result_valid), .result_rd(z_result_rd), .result_data(z_result_data),
        .busy(z_busy), .dbg_addr(z_dbg_addr), .dbg_data(z_dbg_data)
    );

    typedef struct {
        logic [1:0] rd;
        logic [3:0] data;
        int         acc_cyc;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        logic [7:0] instr;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Writeback monitor: every result_valid pulse must match the oldest issued instruction.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            $display("writeback rd=%0d data=%0h cycle=%0d", result_rd, result_data, cyc);
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_writeback: got rd=%0d data=%0h, expected none",
                         result_rd, result_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_rd", 32'(result_rd), 32'(mon_e.rd));
                chk("wb_data", 32'(result_data), 32'(mon_e.data));
                chk("wb_latency", 32'(cyc - mon_e.acc_cyc), 32'd3);
            end
        end
    end

    task automatic do_load(input logic [1:0] addr, input logic [3:0] data);
        int n;
        @(negedge clk);
        load_valid = 1'b1; load_addr = addr; load_data = data;
        n = 0;
        while (!load_ready && n < 50) begin @(negedge clk); n++; end
        if (!load_ready) begin
            checks++; fails++;
            $display("FAIL load_timeout: got load_ready=0, expected 1");
        end
        $display("load r%0d=%0h", addr, data);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic issue(input logic [7:0] instr, input logic [3:0] res,
                         input logic [3:0] ea, input logic [3:0] eb, input bit chk_ops);
        int  n;
        sb_t e;
        @(negedge clk);
        in_valid = 1'b1; in_instr = instr;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!in_ready) begin
            checks++; fails++;
            $display("FAIL issue_timeout: got in_ready=0, expected 1");
            in_valid = 1'b0;
            return;
        end
        e.rd = instr[5:4]; e.data = res; e.acc_cyc = cyc;
        sb_q.push_back(e);
        $display("issue instr=%02h expect rd=%0d data=%0h cycle=%0d", instr, e.rd, res, cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (chk_ops) begin
            chk("alu_rs", 32'(alu_rs), 32'(ea));
            chk("alu_rt", 32'(alu_rt), 32'(eb));
            chk("alu_op", 32'(alu_op), 32'(instr[7:6]));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 100) begin @(negedge clk); n++; end
        if (sb_q.size() != 0 || busy) begin
            checks++; fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
        end
    endtask

    task automatic chk_regs(input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [3:0] e3);
        logic [3:0] exp_r [4];
        exp_r[0] = e0; exp_r[1] = e1; exp_r[2] = e2; exp_r[3] = e3;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("dbg_r%0d", i), 32'(dbg_data), 32'(exp_r[i]));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n_acc, n_busy, n_rv, last, t0;
        sb_t e;

        in_valid = 0; in_instr = '0; load_valid = 0; load_addr = '0; load_data = '0; dbg_addr = '0;
        z_in_valid = 0; z_in_instr = '0; z_load_valid = 0; z_load_addr = '0;
        z_load_data = '0; z_dbg_addr = '0;

        // Vector table: loads r0=3, r1=5 then these run in order
        vecs[0] = '{8'h21, 4'h3, 4'h5, 4'h8};  // ADD r2=r0+r1
        vecs[1] = '{8'h71, 4'h3, 4'h5, 4'hE};  // SUB r3=r0-r1
        vecs[2] = '{8'hBD, 4'hE, 4'h5, 4'h6};  // MUL r3=r3*r1 (70 -> 6)
        vecs[3] = '{8'hCB, 4'h8, 4'h6, 4'hE};  // XOR r0=r2^r3
        vecs[4] = '{8'h15, 4'h5, 4'h5, 4'hA};  // ADD r1=r1+r1
        vecs[5] = '{8'h68, 4'h8, 4'hE, 4'hA};  // SUB r2=r2-r0
        vecs[6] = '{8'h80, 4'hE, 4'hE, 4'h4};  // MUL r0=r0*r0 (196 -> 4)
        vecs[7] = '{8'h3E, 4'h6, 4'hA, 4'h0};  // ADD r3=r3+r2 (16 -> 0)

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_alu_ops", {20'd0, alu_rs, alu_rt, alu_op, 2'd0}, 32'd0);
        chk("rst_result", {26'd0, result_rd, result_data}, 32'd0);
        chk_regs(4'h0, 4'h0, 4'h0, 4'h0);

        do_load(2'd0, 4'h3);
        do_load(2'd1, 4'h5);
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].instr, vecs[i].res, vecs[i].a, vecs[i].b, 1'b1);
            chk("exec_busy", 32'(busy), 32'd1);
        end
        drain();
        chk_regs(4'h4, 4'hA, 4'hA, 4'h0);

        // Load and instruction offered together: load goes first, the ADD sees r2=7
        @(negedge clk);
        load_valid = 1'b1; load_addr = 2'd2; load_data = 4'h7;
        in_valid = 1'b1; in_instr = 8'h18;  // ADD r1=r2+r0
        #1;
        chk("coll_in_ready", 32'(in_ready), 32'd0);
        chk("coll_load_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        chk("coll_in_ready_next", 32'(in_ready), 32'd1);
        e.rd = 2'd1; e.data = 4'hB; e.acc_cyc = cyc;
        sb_q.push_back(e);
        $display("issue instr=18 expect rd=1 data=b cycle=%0d", cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("coll_alu_rs", 32'(alu_rs), 32'h7);
        chk("coll_alu_rt", 32'(alu_rt), 32'h4);
        // A load requested mid-operation must be held off until IDLE
        load_valid = 1'b1; load_addr = 2'd3; load_data = 4'h9;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("busy_load_ready", 32'(load_ready), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("held_load_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        drain();
        chk_regs(4'h4, 4'hB, 4'h7, 4'h9);

        // in_valid held high: XOR r3=r3^r3 accepted every 4 cycles
        @(negedge clk);
        in_valid = 1'b1; in_instr = 8'hFF;
        n_acc = 0; n_busy = 0; last = -1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (busy) n_busy++;
            if (in_ready) begin
                e.rd = 2'd3; e.data = 4'h0; e.acc_cyc = cyc;
                sb_q.push_back(e);
                $display("issue instr=ff expect rd=3 data=0 cycle=%0d", cyc);
                if (last >= 0) chk("stream_interval", 32'(cyc - last), 32'd4);
                last = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stream_accepts", 32'(n_acc), 32'd3);
        chk("stream_busy_cycles", 32'(n_busy), 32'd9);
        drain();

        // Reset during EXEC: no writeback, regfile cleared, back to IDLE
        issue(8'h06, 4'h2, 4'h0, 4'h0, 1'b0);  // ADD r0=r1+r2, aborted
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("in_reset_busy", 32'(busy), 32'd0);
        chk("in_reset_result_valid", 32'(result_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk_regs(4'h0, 4'h0, 4'h0, 4'h0);
        n_rv = 0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid) n_rv++;
        end
        chk("post_reset_no_pulse", 32'(n_rv), 32'd0);

        // Latency-0 instance: ADD r1=r1+r1 with r1=9 -> 2, result at T+2
        @(negedge clk);
        z_load_valid = 1'b1; z_load_addr = 2'd1; z_load_data = 4'h9;
        @(negedge clk);
        z_load_valid = 1'b0;
        z_dbg_addr = 2'd1;
        #1;
        chk("z_load_r1", 32'(z_dbg_data), 32'h9);
        @(negedge clk);
        z_in_valid = 1'b1; z_in_instr = 8'h15;
        #1;
        chk("z_in_ready", 32'(z_in_ready), 32'd1);
        t0 = cyc;
        $display("issue (lat0) instr=15 expect rd=1 data=2 cycle=%0d", t0);
        @(posedge clk);
        #1;
        z_in_valid = 1'b0;
        chk("z_alu_rs", 32'(z_alu_rs), 32'h9);
        chk("z_alu_rt", 32'(z_alu_rt), 32'h9);
        n = 0;
        while (!z_result_valid && n < 10) begin @(negedge clk); n++; end
        if (!z_result_valid) begin
            checks++; fails++;
            $display("FAIL z_result_timeout: got result_valid=0, expected 1");
        end else begin
            $display("writeback (lat0) rd=%0d data=%0h cycle=%0d", z_result_rd, z_result_data, cyc);
            chk("z_latency", 32'(cyc - t0), 32'd2);
            chk("z_result_rd", 32'(z_result_rd), 32'd1);
            chk("z_result_data", 32'(z_result_data), 32'h2);
        end
        @(negedge clk);
        #1;
        chk("z_pulse_width", 32'(z_result_valid), 32'd0);
        chk("z_dbg_r1", 32'(z_dbg_data), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue-side controller for the 4-bit arithmetic unit; the other end of its operand/opcode/result interface.
- Holds a 4-entry x 4-bit register file and accepts 8-bit instructions over a valid/ready handshake.
- Drives rs/rt/op into the ALU, waits a fixed ALU latency, captures the result, and writes it back to the destination register.
- Sits between the top-level pins and the ALU instance.

Parameters:
- DATA_W, 4, operand/result width (must match ALU).
- ALU_LATENCY, 1, cycles from ALU input change to valid alu_result (0 = combinational ALU).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  instruction can be accepted this cycle.
- in_instr  input  8  {op[7:6], rd[5:4], rs[3:2], rt[1:0]}.
- load_valid  input  1  register-load request.
- load_ready  output  1  load accepted this cycle.
- load_addr  input  2  register to load.
- load_data  input  DATA_W  value to load.
- alu_rs  output  DATA_W  operand A to ALU (registered).
- alu_rt  output  DATA_W  operand B to ALU (registered).
- alu_op  output  2  ALU operation select (registered).
- alu_result  input  DATA_W  ALU result.
- result_valid  output  1  one-cycle pulse: writeback occurred.
- result_rd  output  2  destination of the writeback.
- result_data  output  DATA_W  value written back.
- busy  output  1  high in any state other than IDLE.
- dbg_addr  input  2  register-file observation address.
- dbg_data  output  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - regfile = 0; alu_rs/alu_rt/alu_op = 0; result_valid = 0; result_rd/result_data = 0; state = IDLE.
  - An in-flight instruction is aborted with no writeback.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - load_ready = 1.
  - in_ready = ~load_valid; a load has priority and blocks instruction accept that cycle.
  - load_valid = 1: regfile[load_addr] <= load_data at the edge; state stays IDLE.
  - in_valid & in_ready at the edge of cycle T:
    - alu_rs <= regfile[rs], alu_rt <= regfile[rt], alu_op <= op.
    - rd latched; wait counter <= ALU_LATENCY; state -> EXEC.
- EXEC (cycles T+1 .. T+1+ALU_LATENCY):
  - in_ready = load_ready = 0; alu_rs/alu_rt/alu_op held stable.
  - Counter decrements each cycle.
  - At the edge ending the cycle in which counter == 0:
    - regfile[rd] <= alu_result; result_data <= alu_result; result_rd <= rd.
    - state -> DONE.
- DONE (cycle T+2+ALU_LATENCY):
  - result_valid = 1 for exactly this one cycle.
  - in_ready = load_ready = 0; state -> IDLE.
- Throughput: at most one instruction per ALU_LATENCY+3 cycles.
- Instructions execute strictly in order, so there are no read-after-write hazards; rd == rs or rd == rt is legal.
- After DONE, alu_rs/alu_rt/alu_op retain their last values until the next accept.
- Arithmetic belongs to the ALU. Results are passed through unmodified and truncated to DATA_W; divide-by-zero behaviour is the ALU's.
- load_valid outside IDLE: not accepted (load_ready = 0); the requester must hold the request.
- in_valid deasserted before acceptance: no effect.
- dbg_data reflects regfile contents after the edge; there is no write-through bypass.

Test Plan:
- Reset then loads r0=3, r1=5; instr ADD {00,10,00,01} -> alu_rs=3, alu_rt=5, alu_op=00 in cycle T+1; result_valid in cycle T+3 with result_rd=2, result_data=8; dbg r2=8.
- r0=3, r1=5; SUB r3=r0-r1 then MUL r3=r3*r1 -> first writeback 0xE, second 0xE*5=70, low nibble 0x6; r3=6.
- load_valid and in_valid both high in IDLE -> load wins (in_ready=0); instruction accepted the next cycle; in_ready=load_ready=0 throughout EXEC and DONE.
- in_valid held high continuously with ALU_LATENCY=1 -> accepts exactly every 4 cycles; busy high for 3 of every 4 cycles.
- rst_n pulsed low during EXEC -> result_valid never pulses; regfile all 0; state IDLE, in_ready=1 on release.
- ALU_LATENCY=0 with combinational ALU model, ADD r1=r1+r1 with r1=9 -> result_valid at T+2, data 0x2, r1=2.
